// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM encoding and GF(2^8) helpers
// used by the key scheduler and its expansion stage.
package aes_pkg;

  localparam int AES_NR = 10;
  localparam int AES_KW = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } state_t;

  function automatic logic [7:0] xtime(
    input logic [7:0] a
  );
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] r;
    logic [7:0] p;
    r = '0;
    p = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ p;
      p = xtime(p);
    end
    return r;
  endfunction

  // inverse as x^254, then the affine map
  function automatic logic [7:0] sbox(
    input logic [7:0] x
  );
    logic [7:0]  p;
    logic [7:0]  inv;
    logic [15:0] d;
    p   = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p   = gf_mul(p, p);
      inv = gf_mul(inv, p);
    end
    d = {inv, inv};
    return inv ^ d[14:7] ^ d[13:6]
         ^ d[12:5] ^ d[11:4] ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(
    input logic [31:0] w
  );
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]),  sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(
    input logic [3:0] c
  );
    logic [7:0] r;
    unique case (c)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_key_scheduler_if.sv
// Key-load handshake and round-key read port
// between the scheduler and the cipher datapath.
interface aes_key_scheduler_if;

  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;
  logic         rk_valid;
  logic         busy;
  logic         done;

  modport master (
    output key_in,
    output key_valid,
    output rk_idx,
    input  key_ready,
    input  rk_out,
    input  rk_valid,
    input  busy,
    input  done
  );

  modport slave (
    input  key_in,
    input  key_valid,
    input  rk_idx,
    output key_ready,
    output rk_out,
    output rk_valid,
    output busy,
    output done
  );

endinterface

// File: rtl/aes_key_scheduler_key_expansion.sv
// One AES-128 key expansion round: previous round key
// plus round number in, next round key out.
module key_expansion
  import aes_pkg::*;
(
  input  logic [AES_KW-1:0] i_key,
  input  logic [3:0]        i_cnt,
  output logic [AES_KW-1:0] o_key
);

  logic [31:0] w_w0;
  logic [31:0] w_w1;
  logic [31:0] w_w2;
  logic [31:0] w_w3;
  logic [31:0] w_t;
  logic [31:0] w_n0;
  logic [31:0] w_n1;
  logic [31:0] w_n2;
  logic [31:0] w_n3;

  assign w_w0 = i_key[127:96];
  assign w_w1 = i_key[95:64];
  assign w_w2 = i_key[63:32];
  assign w_w3 = i_key[31:0];

  assign w_t = sub_word({w_w3[23:0], w_w3[31:24]})
             ^ {rcon(i_cnt), 24'h0};

  assign w_n0 = w_w0 ^ w_t;
  assign w_n1 = w_w1 ^ w_n0;
  assign w_n2 = w_w2 ^ w_n1;
  assign w_n3 = w_w3 ^ w_n2;

  assign o_key = {w_n0, w_n1, w_n2, w_n3};

endmodule

// File: rtl/aes_key_scheduler.sv
// Sequential AES-128 round-key generator: one expansion
// round per clock into a table read back by round index.
module aes_key_scheduler
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input logic               clk,
  input logic               rst,
  aes_key_scheduler_if.slave bus
);

  localparam logic [3:0] L_NR = 4'(NR);

  state_t r_state;
  state_t w_next;

  logic [3:0]        r_cnt;
  logic [AES_KW-1:0] r_rk [NR+1];
  logic [AES_KW-1:0] r_rk_out;
  logic              r_done;

  logic              w_accept;
  logic              w_last;
  logic [AES_KW-1:0] w_prev;
  logic [AES_KW-1:0] w_exp;
  logic              w_key_ready;
  logic              w_busy;
  logic              w_rk_valid;

  assign w_accept = bus.key_valid & w_key_ready;
  assign w_last   = (r_cnt == L_NR);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next = EXPAND;
      EXPAND:  if (w_last)   w_next = READY;
      READY:   if (w_accept) w_next = EXPAND;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_key_ready = 1'b0;
    w_busy      = 1'b0;
    w_rk_valid  = 1'b0;
    unique case (1'b1)
      (r_state == IDLE): w_key_ready = 1'b1;
      (r_state == EXPAND): w_busy = 1'b1;
      (r_state == READY): begin
        w_key_ready = 1'b1;
        w_rk_valid  = 1'b1;
      end
      default: ;
    endcase
  end

  // cnt is 1..NR while expanding, so cnt-1 stays in the table
  always_comb begin
    w_prev = '0;
    if (r_cnt != 4'd0 && r_cnt <= L_NR)
      w_prev = r_rk[r_cnt - 4'd1];
  end

  key_expansion u_kexp (
    .i_key (w_prev),
    .i_cnt (r_cnt),
    .o_key (w_exp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 4'd0;
      for (int i = 0; i <= NR; i++)
        r_rk[i] <= '0;
    end else if (w_accept) begin
      r_rk[0] <= bus.key_in;
      r_cnt   <= 4'd1;
    end else if (r_state == EXPAND) begin
      r_rk[r_cnt] <= w_exp;
      r_cnt       <= w_last ? 4'd0 : r_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rk_out <= '0;
      r_done   <= 1'b0;
    end else begin
      r_rk_out <= (bus.rk_idx <= L_NR)
                ? r_rk[bus.rk_idx] : '0;
      r_done   <= (r_state == EXPAND) && w_last;
    end
  end

  assign bus.key_ready = w_key_ready;
  assign bus.busy      = w_busy;
  assign bus.rk_valid  = w_rk_valid;
  assign bus.rk_out    = r_rk_out;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_aes_key_scheduler.sv
// Bench for aes_key_scheduler: random and reference keys
// against a word-array FIPS-197 key expansion model.
module tb_aes_key_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;

  aes_key_scheduler_if bif ();

  aes_key_scheduler #(.NR(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] sb [256];

  localparam logic [127:0] FIPS_K  =
    128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_1  =
    128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_10 =
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_1  =
    128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_10 =
    128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  // carry-less product reduced by the AES polynomial
  function automatic logic [7:0] bgmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--)
      if (p[i]) p = p ^ (15'h11b << (i - 8));
    return p[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (bgmul(8'(x), 8'(y)) == 8'h01)
          inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i + 4) % 8]
             ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8]
             ^ inv[(i + 7) % 8] ^ ((8'h63 >> i) & 8'h1) != 0;
      sb[x] = s;
    end
  endtask

  function automatic logic [127:0] model_rk(
    input logic [127:0] key,
    input int           r
  );
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++)
      w[i] = key[127 - 32 * i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sb[t[31:24]], sb[t[23:16]],
              sb[t[15:8]],  sb[t[7:0]]};
        t  = t ^ {rc, 24'h0};
        rc = bgmul(rc, 8'h02);
      end
      w[i] = w[i - 4] ^ t;
    end
    if (r < 0 || r > 10) return '0;
    return {w[4 * r], w[4 * r + 1],
            w[4 * r + 2], w[4 * r + 3]};
  endfunction

  function automatic logic [127:0] rkey();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // caller sits 1 time unit after an edge with key_ready high
  task automatic run_key(
    input  logic [127:0] k,
    output int           lat,
    output int           dones,
    output logic         rv0
  );
    bif.key_in    = k;
    bif.key_valid = 1'b1;
    @(posedge clk); #1;
    bif.key_valid = 1'b0;
    rv0   = bif.rk_valid;
    lat   = 0;
    dones = 0;
    while (!bif.rk_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (bif.done) dones++;
    end
  endtask

  task automatic read_idx(
    input  logic [3:0]   i,
    output logic [127:0] v
  );
    bif.rk_idx = i;
    @(posedge clk); #1;
    v = bif.rk_out;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bif.rk_idx = 4'd0;
    @(posedge clk); #1;
    total++;
    if ({bif.rk_valid, bif.busy, bif.done,
         bif.key_ready} !== 4'b0001) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=0001",
        {bif.rk_valid, bif.busy, bif.done,
         bif.key_ready});
    end
    total++;
    if (bif.rk_out !== '0) begin
      bad++;
      $display("FAIL reset_rk_out got=%h exp=0",
        bif.rk_out);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_fips();
    int           lat;
    int           dn;
    logic         rv0;
    logic [127:0] v;
    run_key(FIPS_K, lat, dn, rv0);
    total++;
    if (lat !== 10) begin
      bad++;
      $display("FAIL fips_latency got=%0d exp=10",
        lat);
    end
    total++;
    if (dn !== 1) begin
      bad++;
      $display("FAIL fips_done got=%0d exp=1", dn);
    end
    read_idx(4'd1, v);
    total++;
    if (v !== FIPS_1) begin
      bad++;
      $display("FAIL fips_idx1 got=%h exp=%h",
        v, FIPS_1);
    end
    read_idx(4'd10, v);
    total++;
    if (v !== FIPS_10) begin
      bad++;
      $display("FAIL fips_idx10 got=%h exp=%h",
        v, FIPS_10);
    end
    for (int i = 0; i <= 10; i++) begin
      read_idx(4'(i), v);
      total++;
      if (v !== model_rk(FIPS_K, i)) begin
        bad++;
        $display("FAIL fips_rk%0d got=%h exp=%h",
          i, v, model_rk(FIPS_K, i));
      end
    end
  endtask

  task automatic test_reload_zero();
    int           lat;
    int           dn;
    logic         rv0;
    logic [127:0] v;
    run_key('0, lat, dn, rv0);
    total++;
    if (rv0 !== 1'b0) begin
      bad++;
      $display("FAIL reload_rv_drop got=%b exp=0",
        rv0);
    end
    total++;
    if (lat !== 10 || dn !== 1) begin
      bad++;
      $display("FAIL reload_timing got=%0d/%0d exp=10/1",
        lat, dn);
    end
    read_idx(4'd1, v);
    total++;
    if (v !== ZERO_1) begin
      bad++;
      $display("FAIL zero_idx1 got=%h exp=%h",
        v, ZERO_1);
    end
    read_idx(4'd10, v);
    total++;
    if (v !== ZERO_10) begin
      bad++;
      $display("FAIL zero_idx10 got=%h exp=%h",
        v, ZERO_10);
    end
    read_idx(4'hF, v);
    total++;
    if (v !== '0) begin
      bad++;
      $display("FAIL idx_f got=%h exp=0", v);
    end
  endtask

  task automatic test_hold_valid();
    logic [127:0] ka;
    logic [127:0] v;
    int           n;
    int           dn;
    int           krb;
    ka = rkey();
    bif.key_in    = ka;
    bif.key_valid = 1'b1;
    @(posedge clk); #1;
    bif.key_in = rkey();
    n   = 0;
    dn  = 0;
    krb = 0;
    while (!bif.rk_valid && n < 40) begin
      if (bif.key_ready !== 1'b0) krb++;
      @(posedge clk); #1;
      n++;
      if (bif.done) dn++;
    end
    bif.key_valid = 1'b0;
    total++;
    if (krb !== 0) begin
      bad++;
      $display("FAIL hold_key_ready got=%0d exp=0",
        krb);
    end
    total++;
    if (n !== 10 || dn !== 1) begin
      bad++;
      $display("FAIL hold_timing got=%0d/%0d exp=10/1",
        n, dn);
    end
    for (int i = 0; i <= 10; i++) begin
      read_idx(4'(i), v);
      total++;
      if (v !== model_rk(ka, i)) begin
        bad++;
        $display("FAIL hold_rk%0d got=%h exp=%h",
          i, v, model_rk(ka, i));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] k;
    logic [127:0] v;
    int           lat;
    int           dn;
    logic         rv0;
    bif.key_in    = rkey();
    bif.key_valid = 1'b1;
    @(posedge clk); #1;
    bif.key_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    total++;
    if (bif.busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_busy got=%b exp=1",
        bif.busy);
    end
    rst = 1'b1;
    bif.rk_idx = 4'd1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if ({bif.rk_valid, bif.busy, bif.done,
         bif.key_ready} !== 4'b0001) begin
      bad++;
      $display("FAIL mid_rst_flags got=%b exp=0001",
        {bif.rk_valid, bif.busy, bif.done,
         bif.key_ready});
    end
    total++;
    if (bif.rk_out !== '0) begin
      bad++;
      $display("FAIL mid_rst_rk_out got=%h exp=0",
        bif.rk_out);
    end
    read_idx(4'd0, v);
    total++;
    if (v !== '0) begin
      bad++;
      $display("FAIL mid_rst_table got=%h exp=0", v);
    end
    k = rkey();
    run_key(k, lat, dn, rv0);
    total++;
    if (lat !== 10 || dn !== 1) begin
      bad++;
      $display("FAIL mid_new_timing got=%0d/%0d exp=10/1",
        lat, dn);
    end
    for (int i = 0; i <= 10; i++) begin
      read_idx(4'(i), v);
      total++;
      if (v !== model_rk(k, i)) begin
        bad++;
        $display("FAIL mid_new_rk%0d got=%h exp=%h",
          i, v, model_rk(k, i));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] k;
    logic [127:0] v;
    int           lat;
    int           dn;
    logic         rv0;
    for (int t = 0; t < 4; t++) begin
      k = rkey();
      run_key(k, lat, dn, rv0);
      total++;
      if (lat !== 10 || dn !== 1) begin
        bad++;
        $display("FAIL b2b%0d_timing got=%0d/%0d exp=10/1",
          t, lat, dn);
      end
      for (int i = 0; i < 16; i++) begin
        read_idx(4'(i), v);
        total++;
        if (v !== model_rk(k, i)) begin
          bad++;
          $display("FAIL b2b%0d_rk%0d got=%h exp=%h",
            t, i, v, model_rk(k, i));
        end
      end
    end
  endtask

  initial begin
    bif.key_in    = '0;
    bif.key_valid = 1'b0;
    bif.rk_idx    = 4'd0;
    build_sbox();
    test_reset();
    test_fips();
    test_reload_zero();
    test_hold_valid();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d",
      total, bad);
    $finish;
  end

endmodule
